// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 frame receiver and the future
// ps2_tx_frame transmitter.
//   ps2_state_e   : frame FSM states (IDLE, DATA, PARITY, STOP)
//   ps2_err_e     : receive error codes reported on rx_err_code
//   PS2_DATA_BITS : payload bits per frame
//   odd_parity_ok : true when the data bits plus the parity bit have odd parity
package ps2_pkg;

  localparam int PS2_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DATA   = 2'b01,
    PARITY = 2'b10,
    STOP   = 2'b11
  } ps2_state_e;

  typedef enum logic [1:0] {
    ERR_START   = 2'b00,
    ERR_PARITY  = 2'b01,
    ERR_STOP    = 2'b10,
    ERR_TIMEOUT = 2'b11
  } ps2_err_e;

  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d,
                                         input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_line_sync_filter.sv
// ps2_line_sync_filter: brings one raw PS/2 line into the main_clk domain
// with a 2-flop synchroniser, then debounces it. The filtered output only
// changes after FILTER_CYCLES consecutive synchronised samples that differ
// from it. Both stages reset high (idle bus level).
// Ports:
//   main_clk  : system clock
//   reset     : asynchronous, active-high
//   line_in   : raw asynchronous line
//   line_filt : synchronised, debounced line
module ps2_line_sync_filter #(
  parameter int FILTER_CYCLES = 16
) (
  input  logic main_clk,
  input  logic reset,
  input  logic line_in,
  output logic line_filt
);

  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;

  // synchroniser
  always_ff @(posedge main_clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= line_in;
      sync_p1 <= sync_p0;
    end
  end

  // debounce: any sample agreeing with the current level restarts the count
  always_ff @(posedge main_clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      line_filt <= 1'b1;
    end else if (sync_p1 == line_filt) begin
      cnt <= '0;
    end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
      cnt       <= '0;
      line_filt <= sync_p1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 device-to-host physical-layer receiver.
// Deserialises 11-bit frames (start, 8 data LSB first, odd parity, stop)
// clocked by the filtered falling edge of the PS/2 clock line.
// Ports:
//   main_clk      : system clock (90 MHz)
//   reset         : asynchronous, active-high
//   ps2_clk_in    : raw PS/2 clock line
//   ps2_data_in   : raw PS/2 data line
//   rx_inhibit    : transmit path owns the bus; receiver held idle, edges ignored
//   rx_byte       : last good byte, held until the next good byte
//   rx_valid      : one-cycle strobe, good byte on rx_byte
//   rx_err        : one-cycle strobe, frame rejected
//   rx_err_code   : 00 start, 01 parity, 10 stop, 11 timeout (valid with rx_err)
//   rx_busy       : frame in progress
// Optional build macro PS2_RX_ERR_COUNT_EN adds:
//   err_count_clr : clears err_count (wins over an increment)
//   err_count     : saturating count of rx_err strobes
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 180000
) (
  input  logic                     main_clk,
  input  logic                     reset,
  input  logic                     ps2_clk_in,
  input  logic                     ps2_data_in,
  input  logic                     rx_inhibit,
  output logic [PS2_DATA_BITS-1:0] rx_byte,
  output logic                     rx_valid,
  output logic                     rx_err,
  output logic [1:0]               rx_err_code,
  output logic                     rx_busy
`ifdef PS2_RX_ERR_COUNT_EN
  ,
  input  logic                     err_count_clr,
  output logic [7:0]               err_count
`endif
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic                     clk_filt;
  logic                     clk_filt_q;
  logic                     data_filt;
  logic                     fall;
  ps2_state_e               state;
  logic [2:0]               bit_cnt;
  logic [PS2_DATA_BITS-1:0] shreg;
  logic                     par_bit;
  logic [TW-1:0]            to_cnt;

  ps2_line_sync_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filt (
    .main_clk  (main_clk),
    .reset     (reset),
    .line_in   (ps2_clk_in),
    .line_filt (clk_filt)
  );

  // data only needs synchronising; a single-sample filter keeps its latency
  // well inside the clock filter's so the bit is settled at the edge
  ps2_line_sync_filter #(.FILTER_CYCLES(1)) u_data_filt (
    .main_clk  (main_clk),
    .reset     (reset),
    .line_in   (ps2_data_in),
    .line_filt (data_filt)
  );

  // edge detect
  always_ff @(posedge main_clk or posedge reset) begin
    if (reset) clk_filt_q <= 1'b1;
    else       clk_filt_q <= clk_filt;
  end

  assign fall    = clk_filt_q & ~clk_filt;
  assign rx_busy = (state != IDLE);

  // frame FSM; priority is inhibit, then edge, then timeout
  always_ff @(posedge main_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      to_cnt      <= '0;
      rx_byte     <= '0;
      rx_valid    <= 1'b0;
      rx_err      <= 1'b0;
      rx_err_code <= ERR_START;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (rx_inhibit) begin
        state   <= IDLE;
        bit_cnt <= '0;
        to_cnt  <= '0;
      end else if (fall) begin
        to_cnt <= '0;
        unique case (state)
          IDLE: begin
            if (!data_filt) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              rx_err      <= 1'b1;
              rx_err_code <= ERR_START;
            end
          end
          DATA: begin
            shreg   <= {data_filt, shreg[PS2_DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= data_filt;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!data_filt) begin
              rx_err      <= 1'b1;
              rx_err_code <= ERR_STOP;
            end else if (!odd_parity_ok(shreg, par_bit)) begin
              rx_err      <= 1'b1;
              rx_err_code <= ERR_PARITY;
            end else begin
              rx_byte  <= shreg;
              rx_valid <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state       <= IDLE;
          bit_cnt     <= '0;
          to_cnt      <= '0;
          rx_err      <= 1'b1;
          rx_err_code <= ERR_TIMEOUT;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

`ifdef PS2_RX_ERR_COUNT_EN
  // saturating error counter
  always_ff @(posedge main_clk or posedge reset) begin
    if (reset)                               err_count <= '0;
    else if (err_count_clr)                  err_count <= '0;
    else if (rx_err && (err_count != 8'hFF)) err_count <= err_count + 1'b1;
  end
`endif

endmodule
